cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the registered 4-bit CLA datapath to WIDTH bits built from 4-bit lookahead groups. GROUPS_PER_STAGE groups are resolved per pipeline stage, and the group carry is registered between stages. It adds a valid/ready stream handshake, add/subtract mode and signed-overflow detection, and sits between operand-producing logic and the result consumer in the arithmetic datapath.

---
 rtl/adder_pkg.sv | 11 +
 rtl/cla4_group.sv | 29 ++
 rtl/cla_pipe_adder.sv | 115 +++++++++++
 tb/tb_cla_pipe_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package adder_pkg;

  localparam int CLA_GROUP_W = 4;

  // Number of lookahead pipeline stages for a given width and groups per stage.
  function automatic int nstage(input int width, input int gps);
    return width / (CLA_GROUP_W * gps);
  endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group: propagate/generate, carries c1..c4 and sum.
module cla4_group
  import adder_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   ci,
  output logic [CLA_GROUP_W-1:0] sum,
  output logic                   c3,
  output logic                   co
);

  logic [CLA_GROUP_W-1:0] p;
  logic [CLA_GROUP_W-1:0] g;
  logic                   c1;
  logic                   c2;

  assign p = a ^ b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign sum = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream handshake.
// Each stage resolves GROUPS_PER_STAGE 4-bit groups and registers the carry into the next one.
module cla_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vdd,
  input  logic             gnd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUP  = WIDTH / CLA_GROUP_W;
  localparam int NSTAGE  = nstage(WIDTH, GROUPS_PER_STAGE);
  localparam int STAGE_W = CLA_GROUP_W * GROUPS_PER_STAGE;

  if (GROUPS_PER_STAGE < 1 || GROUPS_PER_STAGE > NGROUP || (WIDTH % STAGE_W) != 0) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*GROUPS_PER_STAGE, 1 <= GROUPS_PER_STAGE <= WIDTH/4");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
  } stage_t;

  stage_t              pipe_reg [0:NSTAGE];
  stage_t [NSTAGE:1]   pipe_next;
  stage_t              stage0_next;
  logic                adv;

  assign adv      = !pipe_reg[NSTAGE].valid || out_ready;
  assign in_ready = adv && !rst;

  // Subtraction is folded in here as a + ~b + 1, so later stages only ever add.
  always_comb begin
    stage0_next       = '0;
    stage0_next.valid = in_valid;
    stage0_next.a     = a;
    stage0_next.b     = b ^ {WIDTH{sub}};
    stage0_next.c     = sub | cin;
  end

  genvar gi;
  genvar gj;
  for (gi = 1; gi <= NSTAGE; gi++) begin : g_stage
    localparam int BASE = (gi - 1) * STAGE_W;
    logic                carry     [0:GROUPS_PER_STAGE];
    logic                msb_carry [0:GROUPS_PER_STAGE-1];
    logic [STAGE_W-1:0]  grp_sum;
    stage_t              nxt;

    assign carry[0] = pipe_reg[gi-1].c;

    for (gj = 0; gj < GROUPS_PER_STAGE; gj++) begin : g_grp
      cla4_group u_grp (
        .a   (pipe_reg[gi-1].a[BASE + CLA_GROUP_W*gj +: CLA_GROUP_W]),
        .b   (pipe_reg[gi-1].b[BASE + CLA_GROUP_W*gj +: CLA_GROUP_W]),
        .ci  (carry[gj]),
        .sum (grp_sum[CLA_GROUP_W*gj +: CLA_GROUP_W]),
        .c3  (msb_carry[gj]),
        .co  (carry[gj+1])
      );
    end

    // Overflow is only meaningful at the last stage, where the last group holds the MSB.
    always_comb begin
      nxt                    = pipe_reg[gi-1];
      nxt.s[BASE +: STAGE_W] = grp_sum;
      nxt.c                  = carry[GROUPS_PER_STAGE];
      nxt.ovf                = msb_carry[GROUPS_PER_STAGE-1] ^ carry[GROUPS_PER_STAGE];
    end

    assign pipe_next[gi] = nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NSTAGE; i++) begin
        pipe_reg[i] <= '0;
      end
    end else if (adv) begin
      pipe_reg[0] <= stage0_next;
      for (int i = 1; i <= NSTAGE; i++) begin
        pipe_reg[i] <= pipe_next[i];
      end
    end
  end

  assign out_valid = pipe_reg[NSTAGE].valid;
  assign sum       = pipe_reg[NSTAGE].s;
  assign cout      = pipe_reg[NSTAGE].c;
  assign ovf       = pipe_reg[NSTAGE].ovf;

  // Supply pins and spent operand bits have no logical function at the output.
  logic unused_ok;
  assign unused_ok = ^{vdd, gnd, pipe_reg[NSTAGE].a, pipe_reg[NSTAGE].b};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: directed cases plus a randomized stream against an arithmetic reference.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic vdd = 1'b1;
  logic gnd = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  logic        in_valid32 = 1'b0, out_ready32 = 1'b1, cin32 = 1'b0, sub32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        in_ready32, out_valid32, cout32, ovf32;
  logic [31:0] sum32;

  cla_pipe_adder dut16 (
    .clk(clk), .rst(rst), .vdd(vdd), .gnd(gnd),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) dut32 (
    .clk(clk), .rst(rst), .vdd(vdd), .gnd(gnd),
    .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain signed/unsigned arithmetic.
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    int          sx, sy, r;
    logic [16:0] u;
    logic        c, v;
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      r = sx - sy;
      u = {1'b0, x} - {1'b0, y};
      c = (x >= y);
    end else begin
      r = sx + sy + int'(ci);
      u = {1'b0, x} + {1'b0, y} + {16'b0, ci};
      c = u[16];
    end
    v = (r > 32767) || (r < -32768);
    return {v, c, u[15:0]};
  endfunction

  logic [17:0] exp_q[$];
  bit          prev_stall = 1'b0;
  logic [17:0] prev_out;

  task automatic cycle16(input bit iv, input logic [15:0] aa, input logic [15:0] bb,
                         input bit ci, input bit sb, input bit ordy, output bit acc);
    logic [17:0] e;
    @(negedge clk);
    in_valid = iv; a = aa; b = bb; cin = ci; sub = sb; out_ready = ordy;
    #1;
    if (prev_stall) check("stall_hold", 64'({ovf, cout, sum}), 64'(prev_out));
    if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'(0));
    prev_stall = out_valid && !out_ready;
    prev_out   = {ovf, cout, sum};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({ovf, cout, sum}), 64'(e));
      end
    end
    acc = iv && in_ready;
    if (acc) exp_q.push_back(ref16(aa, bb, ci, sb));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_valid32 = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({ovf, cout, sum}), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  // Drives one beat at the current time (just after a negedge) and measures latency.
  task automatic single16(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input bit ci, input bit sb, input logic [17:0] exp);
    int lat;
    in_valid = 1'b1; a = aa; b = bb; cin = ci; sub = sb; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(5));
    check({tag, "_result"}, 64'({ovf, cout, sum}), 64'(exp));
    prev_stall = 1'b0;
  endtask

  task automatic single32(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                          input bit ci, input bit sb, input logic [33:0] exp);
    int lat;
    in_valid32 = 1'b1; a32 = aa; b32 = bb; cin32 = ci; sub32 = sb; out_ready32 = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready32), 64'(1));
    @(negedge clk);
    in_valid32 = 1'b0;
    lat = 1;
    while (!out_valid32 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(5));
    check({tag, "_result"}, 64'({ovf32, cout32, sum32}), 64'(exp));
  endtask

  task automatic drain();
    bit acc;
    for (int n = 0; n < 50 && exp_q.size() > 0; n++) cycle16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bit          acc, hold, riv, rc, rs;
    int          idx, got;
    logic [15:0] ra, rb;

    // Reset state, then carry ripple through every group.
    do_reset(2);
    single16("t1_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    single16("t2_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    single16("t2_sub", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});

    // Back-to-back stream with a 3-cycle consumer stall.
    idx = 0;
    for (int c = 0; c < 30 && idx < 8; c++) begin
      cycle16(1'b1, 16'(idx), 16'(16'h1000 * idx), 1'b0, 1'b0, !(c >= 6 && c < 9), acc);
      if (acc) idx++;
    end
    check("t3_accepted", 64'(idx), 64'(8));
    drain();

    // Reset with three beats in flight; none of them may appear afterwards.
    for (int i = 0; i < 3; i++) cycle16(1'b1, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0, 1'b1, acc);
    do_reset(1);
    single16("t4_after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
    for (int i = 0; i < 10; i++) cycle16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);

    // Wider instance, two groups per stage.
    @(negedge clk);
    single32("t5_w32", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0001});

    // Random stream with random backpressure; operands held while not accepted.
    hold = 1'b0; got = 0;
    riv = 1'b0; ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      if (!hold) begin
        riv = ($urandom_range(3) != 0);
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rc  = 1'($urandom);
        rs  = 1'($urandom);
        if ($urandom_range(7) == 0) ra = 16'h7FFF + 16'($urandom_range(2));
        if ($urandom_range(7) == 0) rb = 16'hFFFF - 16'($urandom_range(1));
      end
      cycle16(riv, ra, rb, rc, rs, $urandom_range(3) != 0, acc);
      hold = riv && !acc;
      if (acc) got++;
    end
    check("t6_beats", 64'(got), 64'(10000));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
